mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multicycle RV32 control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB), with a sticky HALT.
// Define ILLEGAL_TRAP_EN to halt on unknown opcodes; by default they retire as NOPs.

`ifndef OPCODE_LOAD
`define OPCODE_LOAD    7'b0000011
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE   7'b0100011
`endif
`ifndef OPCODE_ARITH_R
`define OPCODE_ARITH_R 7'b0110011
`endif
`ifndef OPCODE_ARITH_I
`define OPCODE_ARITH_I 7'b0010011
`endif
`ifndef OPCODE_LUI
`define OPCODE_LUI     7'b0110111
`endif
`ifndef OPCODE_AUIPC
`define OPCODE_AUIPC   7'b0010111
`endif
`ifndef OPCODE_JAL
`define OPCODE_JAL     7'b1101111
`endif
`ifndef OPCODE_JALR
`define OPCODE_JALR    7'b1100111
`endif
`ifndef OPCODE_BRANCH
`define OPCODE_BRANCH  7'b1100011
`endif
`ifndef OPCODE_FENCE
`define OPCODE_FENCE   7'b0001111
`endif
`ifndef OPCODE_SYSTEM
`define OPCODE_SYSTEM  7'b1110011
`endif

module mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        halted_q, halted_d;
  logic [31:0] instret_q, instret_d;

  logic [6:0] opcode;
  logic       is_load, is_store, is_arith_r, is_arith_i, is_lui, is_auipc;
  logic       is_jal, is_jalr, is_branch, is_fence, is_system;
  logic       is_wb_class, trap_illegal;
  logic       unused_ir;

  assign opcode     = IR[6:0];
  assign unused_ir  = ^IR[31:7];
  assign is_load    = (opcode == `OPCODE_LOAD);
  assign is_store   = (opcode == `OPCODE_STORE);
  assign is_arith_r = (opcode == `OPCODE_ARITH_R);
  assign is_arith_i = (opcode == `OPCODE_ARITH_I);
  assign is_lui     = (opcode == `OPCODE_LUI);
  assign is_auipc   = (opcode == `OPCODE_AUIPC);
  assign is_jal     = (opcode == `OPCODE_JAL);
  assign is_jalr    = (opcode == `OPCODE_JALR);
  assign is_branch  = (opcode == `OPCODE_BRANCH);
  assign is_fence   = (opcode == `OPCODE_FENCE);
  assign is_system  = (opcode == `OPCODE_SYSTEM);

  // Instructions that finish by writing the register file.
  assign is_wb_class = is_arith_r | is_arith_i | is_lui | is_auipc | is_jal | is_jalr;

`ifdef ILLEGAL_TRAP_EN
  assign trap_illegal = ~(is_load | is_store | is_wb_class | is_branch | is_fence | is_system);
`else
  assign trap_illegal = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    pc_sel    = 2'b00;
    wb_sel    = 2'b00;
    alu_src_b = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end
      end

      StDecode: begin
        state_d = (is_system || trap_illegal) ? StHalt : StExec;
      end

      StExec: begin
        alu_src_b = ~(is_arith_r | is_branch);
        if (is_load || is_store) begin
          state_d = StMem;
        end else if (is_wb_class) begin
          state_d = StWb;
        end else begin
          // Branch, FENCE and untrapped unknown opcodes retire here.
          pc_we   = 1'b1;
          pc_sel  = (is_branch && br_taken) ? 2'b01 : 2'b00;
          state_d = StFetch;
        end
      end

      StMem: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_d = StWb;
          end else begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end
        end
      end

      StWb: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        wb_sel  = is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
        pc_sel  = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
        state_d = StFetch;
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StFetch;
      end
    endcase

    // Strobes stay low while reset is held, so no request starts before release.
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      pc_sel    = 2'b00;
      wb_sel    = 2'b00;
      alu_src_b = 1'b0;
    end
  end

  assign halted_d  = (state_d == StHalt);
  assign instret_d = instret_q + {31'b0, pc_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      halted_q  <= 1'b0;
      instret_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign halted  = halted_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed vector table, corner-case sequences and
// randomized instructions checked cycle by cycle against a path-based reference model.

module tb_mc_ctrl;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpArithR = 7'b0110011;
  localparam logic [6:0] OpArithI = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        mem_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, alu_src_b, halted;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = 32'h0;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       asel;
    logic       irwe;
    logic       pcwe;
    logic       rfwe;
    logic [1:0] pcs;
    logic [1:0] wbs;
    logic       alub;
    logic       hlt;
  } outs_t;

  outs_t act;
  assign act = {state, mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, pc_sel, wb_sel,
                alu_src_b, halted};

  mc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .IR        (IR),
    .mem_ready (mem_ready),
    .br_taken  (br_taken),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .rf_we     (rf_we),
    .pc_sel    (pc_sel),
    .wb_sel    (wb_sel),
    .alu_src_b (alu_src_b),
    .state     (state),
    .halted    (halted),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  function automatic bit rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic chk_outs(input string nm, input outs_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: outputs got %h (state %0d) want %h (state %0d) IR=%h", nm, act,
               act.st, e, e.st, IR);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Drive one cycle at the falling edge, compare outputs, then advance to the next falling edge.
  task automatic cyc(input logic mr, input logic br, input outs_t e, input string nm);
    mem_ready = mr;
    br_taken  = br;
    #2;
    chk_outs(nm, e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    br_taken  = rb();
    #2;
    chk_outs("reset_outs", '0);
    chk32("reset_instret", instret, 32'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    exp_instret = 32'h0;
  endtask

  // Reference model: derive the expected cycle path of one instruction from its class.
  task automatic run_instr(input logic [31:0] ir, input bit br, input int fw, input int mw,
                           output bit hlt);
    logic [6:0] op;
    outs_t      e;
    bit         ld, st, wbc, ill;
    op  = ir[6:0];
    IR  = ir;
    ld  = (op == OpLoad);
    st  = (op == OpStore);
    wbc = op inside {OpArithR, OpArithI, OpLui, OpAuipc, OpJal, OpJalr};
    ill = !(op inside {OpLoad, OpStore, OpArithR, OpArithI, OpLui, OpAuipc, OpJal, OpJalr,
                       OpBranch, OpFence, OpSystem});
    hlt = (op == OpSystem) || (TrapEn && ill);

    for (int k = 0; k <= fw; k++) begin
      e = '0; e.req = 1'b1; e.irwe = (k == fw);
      cyc(k == fw, rb(), e, "fetch");
    end
    e = '0; e.st = 3'd1;
    cyc(rb(), rb(), e, "decode");

    if (hlt) begin
      e = '0; e.st = 3'd5; e.hlt = 1'b1;
      cyc(rb(), rb(), e, "halt_entry");
      chk32("halt_instret", instret, exp_instret);
      return;
    end

    e = '0; e.st = 3'd2; e.alub = !(op == OpArithR || op == OpBranch);
    if (!(ld || st || wbc)) begin
      e.pcwe = 1'b1;
      e.pcs  = (op == OpBranch && br) ? 2'b01 : 2'b00;
    end
    cyc(rb(), br, e, "exec");

    if (ld || st) begin
      for (int k = 0; k <= mw; k++) begin
        e = '0; e.st = 3'd3; e.req = 1'b1; e.asel = 1'b1; e.we = st;
        e.pcwe = st && (k == mw);
        cyc(k == mw, rb(), e, "mem");
      end
    end

    if (ld || wbc) begin
      e = '0; e.st = 3'd4; e.rfwe = 1'b1; e.pcwe = 1'b1;
      e.wbs = ld ? 2'b01 : ((op == OpJal || op == OpJalr) ? 2'b10 : 2'b00);
      e.pcs = (op == OpJal) ? 2'b01 : ((op == OpJalr) ? 2'b10 : 2'b00);
      cyc(rb(), rb(), e, "wb");
    end

    exp_instret = exp_instret + 32'd1;
    chk32("instret", instret, exp_instret);
  endtask

  typedef struct {
    logic [31:0] ir;
    bit          br;
    int          fw;
    int          mw;
    logic [31:0] d;
    bit          halts;
    string       nm;
  } vec_t;

  vec_t        vt[12];
  logic [6:0]  pool[10];

  initial begin
    bit          h;
    logic [31:0] base;
    outs_t       e;

    vt[0]  = '{32'h00500093, 1'b0, 0, 0, 32'd1, 1'b0, "addi"};
    vt[1]  = '{32'h0000a103, 1'b0, 1, 3, 32'd1, 1'b0, "lw_wait3"};
    vt[2]  = '{32'h0020a023, 1'b0, 0, 2, 32'd1, 1'b0, "sw"};
    vt[3]  = '{32'h00208463, 1'b1, 0, 0, 32'd1, 1'b0, "beq_taken"};
    vt[4]  = '{32'h00208463, 1'b0, 2, 0, 32'd1, 1'b0, "beq_not"};
    vt[5]  = '{32'h008000ef, 1'b0, 0, 0, 32'd1, 1'b0, "jal"};
    vt[6]  = '{32'h000080e7, 1'b1, 0, 0, 32'd1, 1'b0, "jalr"};
    vt[7]  = '{32'h123450b7, 1'b0, 1, 0, 32'd1, 1'b0, "lui"};
    vt[8]  = '{32'h00001097, 1'b0, 0, 0, 32'd1, 1'b0, "auipc"};
    vt[9]  = '{32'h002081b3, 1'b1, 0, 0, 32'd1, 1'b0, "add"};
    vt[10] = '{32'h0000000f, 1'b0, 0, 0, 32'd1, 1'b0, "fence"};
`ifdef ILLEGAL_TRAP_EN
    vt[11] = '{32'h0000007f, 1'b0, 0, 0, 32'd0, 1'b1, "illegal"};
`else
    vt[11] = '{32'h0000007f, 1'b0, 0, 0, 32'd1, 1'b0, "illegal"};
`endif

    pool = '{OpLoad, OpStore, OpArithR, OpArithI, OpLui, OpAuipc, OpJal, OpJalr, OpBranch,
             OpFence};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      base = exp_instret;
      run_instr(vt[i].ir, vt[i].br, vt[i].fw, vt[i].mw, h);
      chk32({"tbl_instret_", vt[i].nm}, instret, base + vt[i].d);
      chk32({"tbl_halted_", vt[i].nm}, {31'b0, halted}, {31'b0, vt[i].halts});
      if (vt[i].halts) do_reset();
    end

    // JALR then ECALL: halt must persist until reset.
    run_instr(32'h000080e7, 1'b0, 0, 0, h);
    base = exp_instret;
    run_instr(32'h00000073, 1'b0, 1, 0, h);
    for (int k = 0; k < 10; k++) begin
      e = '0; e.st = 3'd5; e.hlt = 1'b1;
      cyc(rb(), rb(), e, "halt_hold");
    end
    chk32("halt_hold_instret", instret, base);
    do_reset();

    // Asynchronous reset in the middle of a Store's MEM wait.
    run_instr(32'h00500093, 1'b0, 0, 0, h);
    IR = 32'h0020a023;
    e = '0; e.req = 1'b1; e.irwe = 1'b1;
    cyc(1'b1, 1'b0, e, "st_fetch");
    e = '0; e.st = 3'd1;
    cyc(1'b0, 1'b0, e, "st_decode");
    e = '0; e.st = 3'd2; e.alub = 1'b1;
    cyc(1'b0, 1'b0, e, "st_exec");
    e = '0; e.st = 3'd3; e.req = 1'b1; e.asel = 1'b1; e.we = 1'b1;
    cyc(1'b0, 1'b0, e, "st_mem_wait");
    mem_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_outs("mid_mem_reset", '0);
    chk32("mid_mem_reset_instret", instret, 32'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    exp_instret = 32'h0;

    // Preload instret to all-ones during a FETCH stall, then retire once to wrap.
    IR = 32'h00500093;
    force dut.instret_q = 32'hffffffff;
    e = '0; e.req = 1'b1;
    cyc(1'b0, 1'b0, e, "force_fetch");
    release dut.instret_q;
    chk32("forced_instret", instret, 32'hffffffff);
    exp_instret = 32'hffffffff;
    run_instr(32'h00500093, 1'b0, 0, 0, h);
    chk32("instret_wrap", instret, 32'h0);

    // Randomized instruction stream.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] rir;
      rir = {25'($urandom), pool[$urandom_range(9, 0)]};
      run_instr(rir, rb(), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), h);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
